btn_debounce: RTL

Input conditioning stage that sits directly upstream of the valid-in pulse state machine and drives its `btn` input. It synchronises a raw, asynchronous push-button level into the `clk` domain and filters contact bounce. It outputs a clean, registered level that changes only after the synchronised input has stayed constant for a programmable number of cycles. The current FSM state is exported for bench visibility.

---
 rtl/btn_debounce.sv | 111 +++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchroniser followed by a four-state debounce FSM.
//                A new button level is accepted only once the synchronised
//                input has held steady for DEBOUNCE_CYCLES consecutive cycles.
//                The debounced level comes straight off the state register.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn,
    output logic [1:0] state_test
);

    // State encoding; bit 1 doubles as the debounced output level.
    localparam logic [1:0] c_idle_low  = 2'd0;
    localparam logic [1:0] c_wait_high = 2'd1;
    localparam logic [1:0] c_idle_high = 2'd2;
    localparam logic [1:0] c_wait_low  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [1:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State and stability counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle_low;
            r_cnt   <= c_cnt_zero;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; an input change always beats terminal
    // count, so an aborted transition never reaches the accept state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_idle_low: begin
                if (r_sync2) begin
                    w_state_nxt = c_wait_high;
                    w_cnt_nxt   = c_cnt_zero;
                end
            end
            c_wait_high: begin
                if (!r_sync2) begin
                    w_state_nxt = c_idle_low;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_idle_high;
                    w_cnt_nxt   = c_cnt_zero;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            c_idle_high: begin
                if (!r_sync2) begin
                    w_state_nxt = c_wait_low;
                    w_cnt_nxt   = c_cnt_zero;
                end
            end
            c_wait_low: begin
                if (r_sync2) begin
                    w_state_nxt = c_idle_high;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_idle_low;
                    w_cnt_nxt   = c_cnt_zero;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = c_idle_low;
                w_cnt_nxt   = c_cnt_zero;
            end
        endcase
    end

    assign state_test = r_state;
    assign btn        = r_state[1];

endmodule
`default_nettype wire
